// File: rtl/adc_pkt_builder.sv
// Packet sequencer for one digitizer channel: header, formatted ADC data words, XOR checksum.
// Optional build macro ADC_PKT_OVR_LSB_EN keeps each sample's overrange flag in lane bit 0.
module adc_pkt_builder #(
    parameter int NPAIR  = 4,
    parameter int SW     = 12,
    parameter int LANE_W = 16,
    localparam int PW    = 2 * (SW + 1),
    localparam int OUT_W = 2 * NPAIR * LANE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [23:0]           fill_num,
    input  logic [22:0]           burst_start_adr,
    input  logic [20:0]           num_fill_bursts,
    input  logic [15:0]           channel_tag,
    input  logic [1:0]            fill_type,
    input  logic [NPAIR*PW-1:0]   dat,
    input  logic                  dat_valid,
    output logic                  dat_ready,
    output logic [OUT_W-1:0]      out_dat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic [15:0]           ovr_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_t;

    state_t             state_reg;
    logic [OUT_W-1:0]   out_dat_reg;
    logic               out_valid_reg;
    logic               out_last_reg;
    logic               busy_reg;
    logic [15:0]        ovr_cnt_reg;
    logic [OUT_W-1:0]   csum_reg;
    logic [20:0]        n_bursts_reg;
    logic [20:0]        word_cnt_reg;

    logic [OUT_W-1:0]   hdr_word;
    logic [OUT_W-1:0]   fmt_word;
    logic [2*NPAIR-1:0] ovr_bits;
    logic [15:0]        ovr_sum;
    logic [16:0]        ovr_total;
    logic               reg_free;
    logic               dat_accept;
    logic               last_word;

    assign reg_free   = !out_valid_reg || out_ready;
    assign dat_ready  = (state_reg == ST_DATA) && reg_free;
    assign dat_accept = dat_valid && dat_ready;
    // Compare with one extra bit so a full-range burst count never wraps.
    assign last_word  = (({1'b0, word_cnt_reg} + 22'd1) == {1'b0, n_bursts_reg});

    assign out_dat   = out_dat_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;
    assign ovr_cnt   = ovr_cnt_reg;

    always_comb begin
        hdr_word                = '0;
        hdr_word[23:0]          = fill_num;
        hdr_word[57:32]         = {burst_start_adr, 3'b000};
        hdr_word[84:64]         = num_fill_bursts;
        hdr_word[111:96]        = channel_tag;
        hdr_word[113:112]       = fill_type;
        hdr_word[OUT_W-1 -: 2]  = 2'b01;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NPAIR; gi++) begin : g_pair
            logic [PW-1:0] pair;
            logic [SW-1:0] s_even;
            logic [SW-1:0] s_odd;
            assign pair   = dat[PW*gi +: PW];
            assign s_even = pair[SW:1];
            assign s_odd  = pair[2*SW+1:SW+2];
            assign ovr_bits[2*gi]   = pair[0];
            assign ovr_bits[2*gi+1] = pair[SW+1];
`ifdef ADC_PKT_OVR_LSB_EN
            assign fmt_word[LANE_W*(2*gi) +: LANE_W] =
                {{(LANE_W-SW){s_even[SW-1]}}, s_even[SW-2:0], pair[0]};
            assign fmt_word[LANE_W*(2*gi+1) +: LANE_W] =
                {{(LANE_W-SW){s_odd[SW-1]}}, s_odd[SW-2:0], pair[SW+1]};
`else
            assign fmt_word[LANE_W*(2*gi) +: LANE_W] =
                {{(LANE_W-SW){s_even[SW-1]}}, s_even};
            assign fmt_word[LANE_W*(2*gi+1) +: LANE_W] =
                {{(LANE_W-SW){s_odd[SW-1]}}, s_odd};
`endif
        end
    endgenerate

    always_comb begin
        ovr_sum = '0;
        for (int i = 0; i < 2 * NPAIR; i++) begin
            ovr_sum = ovr_sum + 16'(ovr_bits[i]);
        end
        ovr_total = {1'b0, ovr_cnt_reg} + {1'b0, ovr_sum};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            out_dat_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            ovr_cnt_reg   <= '0;
            csum_reg      <= '0;
            n_bursts_reg  <= '0;
            word_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        n_bursts_reg  <= num_fill_bursts;
                        word_cnt_reg  <= '0;
                        ovr_cnt_reg   <= '0;
                        out_dat_reg   <= hdr_word;
                        csum_reg      <= hdr_word;
                        out_valid_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= (n_bursts_reg == '0) ? ST_CSUM : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (dat_accept) begin
                        out_dat_reg   <= fmt_word;
                        out_valid_reg <= 1'b1;
                        csum_reg      <= csum_reg ^ fmt_word;
                        word_cnt_reg  <= word_cnt_reg + 21'd1;
                        ovr_cnt_reg   <= ovr_total[16] ? 16'hFFFF : ovr_total[15:0];
                        if (last_word) begin
                            state_reg <= ST_CSUM;
                        end
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                ST_CSUM: begin
                    // out_last marks that the checksum already sits in the output register.
                    if (!out_last_reg) begin
                        if (reg_free) begin
                            out_dat_reg   <= csum_reg;
                            out_valid_reg <= 1'b1;
                            out_last_reg  <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_pkt_builder.sv
// Scoreboard bench for adc_pkt_builder: default instance plus a wide (NPAIR=8, SW=14) instance.
module tb_adc_pkt_builder;
    localparam int NPAIR = 4, SW = 12, LANE_W = 16, PW = 26, OUT_W = 128;
    localparam int P2_PAIR = 8, P2_SW = 14, P2_PW = 30, P2_W = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst = 1'b1, start = 1'b0;
    logic [23:0]         fill_num = '0;
    logic [22:0]         burst_start_adr = '0;
    logic [20:0]         num_fill_bursts = '0;
    logic [15:0]         channel_tag = '0;
    logic [1:0]          fill_type = '0;
    logic [NPAIR*PW-1:0] dat = '0;
    logic                dat_valid = 1'b0, dat_ready;
    logic [OUT_W-1:0]    out_dat;
    logic                out_valid, out_ready = 1'b1, out_last, busy;
    logic [15:0]         ovr_cnt;

    logic                      p2_start = 1'b0, p2_dat_valid = 1'b0, p2_dat_ready;
    logic [P2_PAIR*P2_PW-1:0]  p2_dat = '0;
    logic [P2_W-1:0]           p2_out_dat;
    logic                      p2_out_valid, p2_out_ready = 1'b1, p2_out_last, p2_busy;
    logic [15:0]               p2_ovr_cnt;

    adc_pkt_builder dut (
        .clk(clk), .rst(rst), .start(start), .fill_num(fill_num),
        .burst_start_adr(burst_start_adr), .num_fill_bursts(num_fill_bursts),
        .channel_tag(channel_tag), .fill_type(fill_type), .dat(dat),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .out_dat(out_dat),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .ovr_cnt(ovr_cnt)
    );

    adc_pkt_builder #(.NPAIR(P2_PAIR), .SW(P2_SW), .LANE_W(16)) dut_wide (
        .clk(clk), .rst(rst), .start(p2_start), .fill_num(fill_num),
        .burst_start_adr(burst_start_adr), .num_fill_bursts(num_fill_bursts),
        .channel_tag(channel_tag), .fill_type(fill_type), .dat(p2_dat),
        .dat_valid(p2_dat_valid), .dat_ready(p2_dat_ready), .out_dat(p2_out_dat),
        .out_valid(p2_out_valid), .out_ready(p2_out_ready), .out_last(p2_out_last),
        .busy(p2_busy), .ovr_cnt(p2_ovr_cnt)
    );

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             last;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0, fails = 0;
    bit   bp_en = 1'b0;

    // Backpressure pattern: out_ready toggles every cycle while enabled.
    always @(posedge clk) begin
        #1;
        if (bp_en) out_ready = ~out_ready;
    end

    // Output monitor: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_word: got %h last=%b, expected no word", out_dat, out_last);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_dat !== e.data || out_last !== e.last) begin
                    fails++;
                    $display("FAIL out_word: got %h last=%b, expected %h last=%b",
                             out_dat, out_last, e.data, e.last);
                end else begin
                    $display("[TB] word %h last=%b ok", out_dat, out_last);
                end
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b0) begin
            tests++;
            if (dat_ready !== 1'b0) begin
                fails++;
                $display("FAIL dat_ready_stall: got %b, expected 0", dat_ready);
            end
        end
    end

    function automatic logic [OUT_W-1:0] make_hdr(input logic [23:0] fn, input logic [22:0] adr,
                                                  input logic [20:0] n, input logic [15:0] tag,
                                                  input logic [1:0] ft);
        return {2'b01, 12'b0, ft, tag, 11'b0, n, 6'b0, adr, 3'b0, 8'b0, fn};
    endfunction

    // pattern 0: alternating 0x7FF/0x800; 1: random; 2: alternating with all overrange set.
    task automatic run_fill(input logic [23:0] fn, input logic [22:0] adr, input logic [20:0] n,
                            input logic [15:0] tag, input logic [1:0] ft, input int pattern,
                            input int abort_after, input bit poke_start);
        logic [OUT_W-1:0] csum, e;
        logic [SW-1:0]    s[2*NPAIR];
        logic             o[2*NPAIR];
        bit               hs;
        int               v;
        @(posedge clk); #1;
        start = 1'b1; fill_num = fn; burst_start_adr = adr; num_fill_bursts = n;
        channel_tag = tag; fill_type = ft;
        csum = make_hdr(fn, adr, n, tag, ft);
        exp_q.push_back('{csum, 1'b0});
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_start: got %b, expected 1", busy);
        end
        for (int w = 0; w < int'(n); w++) begin
            e = '0;
            for (int k = 0; k < 2 * NPAIR; k++) begin
                s[k] = (pattern == 1) ? SW'($urandom_range(0, 4095)) : ((k % 2 == 0) ? 12'h7FF : 12'h800);
                o[k] = (pattern == 2);
                v = s[k][SW-1] ? int'(s[k]) - 4096 : int'(s[k]);
`ifdef ADC_PKT_OVR_LSB_EN
                e[LANE_W*k +: LANE_W] = 16'(v * 2 + int'(o[k]));
`else
                e[LANE_W*k +: LANE_W] = 16'(v);
`endif
            end
            for (int i = 0; i < NPAIR; i++) dat[PW*i +: PW] = {s[2*i+1], o[2*i+1], s[2*i], o[2*i]};
            dat_valid = 1'b1;
            exp_q.push_back('{e, 1'b0});
            csum = csum ^ e;
            hs = 1'b0;
            for (int c = 0; c < 200 && !hs; c++) begin
                @(negedge clk);
                hs = dat_valid && dat_ready;
            end
            tests++;
            if (!hs) begin
                fails++;
                $display("FAIL dat_handshake_timeout: got no handshake, expected one within 200 cycles");
            end
            @(posedge clk); #1;
            dat_valid = 1'b0;
            if (poke_start && w == 1) begin
                start = 1'b1; fill_num = 24'hFFFFFF; num_fill_bursts = 21'd3;
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (abort_after != 0 && w + 1 == abort_after) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                tests++;
                if ({out_valid, out_last, dat_ready, busy} !== 4'b0 || out_dat !== '0 || ovr_cnt !== 16'd0) begin
                    fails++;
                    $display("FAIL abort_outputs: got valid=%b last=%b rdy=%b busy=%b ovr=%0d dat=%h, expected all 0",
                             out_valid, out_last, dat_ready, busy, ovr_cnt, out_dat);
                end
                tests++;
                if (exp_q.size() != 0) begin
                    fails++;
                    $display("FAIL abort_queue: got %0d pending words, expected 0", exp_q.size());
                end
                exp_q.delete();
                $display("[TB] fill aborted after word %0d", w + 1);
                return;
            end
        end
        exp_q.push_back('{csum, 1'b1});
        hs = 1'b0;
        for (int c = 0; c < 400 && !hs; c++) begin
            @(negedge clk);
            hs = (busy == 1'b0);
        end
        tests++;
        if (!hs || exp_q.size() != 0) begin
            fails++;
            $display("FAIL fill_end: got busy=%b pending=%0d, expected busy=0 pending=0", busy, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({out_valid, out_last, dat_ready, busy} !== 4'b0 || out_dat !== '0 || ovr_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_state: got valid=%b last=%b rdy=%b busy=%b ovr=%0d, expected all 0",
                     out_valid, out_last, dat_ready, busy, ovr_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        run_fill(24'h123456, 23'h000010, 21'd2, 16'hBEEF, 2'd2, 0, 0, 1'b0);
        tests++;
        if (ovr_cnt !== 16'd0) begin
            fails++;
            $display("FAIL basic_ovr_cnt: got %0d, expected 0", ovr_cnt);
        end
    endtask

    task automatic test_zero_bursts();
        logic [OUT_W-1:0] h;
        int cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; fill_num = 24'h00A5A5; burst_start_adr = 23'h7FFFFF;
        num_fill_bursts = 21'd0; channel_tag = 16'h1234; fill_type = 2'd1;
        h = make_hdr(24'h00A5A5, 23'h7FFFFF, 21'd0, 16'h1234, 2'd1);
        exp_q.push_back('{h, 1'b0});
        exp_q.push_back('{h, 1'b1});
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy) cnt++;
            else break;
        end
        tests++;
        if (cnt != 3 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL zero_bursts: got busy_cycles=%0d pending=%0d, expected 3 and 0", cnt, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bp_en = 1'b1;
        run_fill(24'h000777, 23'h001234, 21'd16, 16'hCAFE, 2'd3, 1, 0, 1'b1);
        bp_en = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
    endtask

    task automatic test_overrange();
        run_fill(24'h000042, 23'h000001, 21'd3, 16'h0F0F, 2'd0, 2, 0, 1'b0);
        tests++;
        if (ovr_cnt !== 16'd24) begin
            fails++;
            $display("FAIL ovr_cnt: got %0d, expected 24", ovr_cnt);
        end
    endtask

    task automatic test_abort();
        run_fill(24'h0000AB, 23'h000100, 21'd10, 16'h5555, 2'd1, 1, 5, 1'b0);
        run_fill(24'h0000AC, 23'h000200, 21'd4, 16'h6666, 2'd2, 0, 0, 1'b0);
    endtask

    task automatic test_params();
        logic [P2_PW-1:0] pair;
        logic [15:0]      exp_lane;
`ifdef ADC_PKT_OVR_LSB_EN
        exp_lane = 16'hC000;
`else
        exp_lane = 16'hE000;
`endif
        pair = {14'h2000, 1'b0, 14'h2000, 1'b0};
        @(posedge clk); #1;
        p2_start = 1'b1; fill_num = 24'hABCDEF; num_fill_bursts = 21'd1;
        burst_start_adr = '0; channel_tag = '0; fill_type = '0;
        @(posedge clk); #1;
        p2_start = 1'b0;
        @(negedge clk);
        tests++;
        if (p2_out_valid !== 1'b1 || p2_out_dat[255:254] !== 2'b01 || p2_out_dat[23:0] !== 24'hABCDEF) begin
            fails++;
            $display("FAIL wide_header: got valid=%b tag=%b fill=%h, expected 1, 01, abcdef",
                     p2_out_valid, p2_out_dat[255:254], p2_out_dat[23:0]);
        end
        @(posedge clk); #1;
        p2_dat = {P2_PAIR{pair}};
        p2_dat_valid = 1'b1;
        @(posedge clk); #1;
        p2_dat_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (p2_out_valid !== 1'b1 || p2_out_dat[15:0] !== exp_lane || p2_out_dat[255:240] !== exp_lane) begin
            fails++;
            $display("FAIL wide_data: got valid=%b lane0=%h lane15=%h, expected 1 and %h",
                     p2_out_valid, p2_out_dat[15:0], p2_out_dat[255:240], exp_lane);
        end
        @(negedge clk);
        tests++;
        if (p2_out_last !== 1'b1 || p2_out_dat[15:0] !== (16'hCDEF ^ exp_lane) || p2_out_dat[255:254] !== 2'b10) begin
            fails++;
            $display("FAIL wide_csum: got last=%b low=%h top=%b, expected 1, %h, 10",
                     p2_out_last, p2_out_dat[15:0], p2_out_dat[255:254], 16'hCDEF ^ exp_lane);
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_bursts();
        test_backpressure();
        test_overrange();
        test_abort();
        test_params();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
